mux_tt_sequencer: RTL and testbench
===================================

# mux_tt_sequencer

Sequential stimulus and checker stage for the two-input mux `mux_a_not_a`, where `y = c ? ~a : a`. It drives the mux's `a` and `c` inputs through all four combinations and samples the mux's `y` output after a settle interval. Each sample is compared against an expected truth table and reported through a valid/ready handshake, with a running mismatch count. It sits directly upstream and downstream of the mux, replacing the open-loop `#10` stepping with a clocked, self-checking sweep.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before `y_i` is sampled; legal range 1..15.
- `EXP_TABLE`, default 4'b0110: expected `y`, indexed by `{a,c}`; the default is XOR.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: starts a sweep when sampled high in IDLE.
- `a_o` out 1: drives mux input `a`.
- `c_o` out 1: drives mux input `c`.
- `y_i` in 1: mux output `y`.
- `res_valid` out 1: a result is presented.
- `res_ready` in 1: consumer accepts the result.
- `res_idx` out 2: `{a,c}` index of the presented result.
- `res_y` out 1: sampled `y_i`.
- `res_ok` out 1: `res_y == EXP_TABLE[res_idx]`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the sweep ends.
- `err_count` out 3: number of mismatches in the current or last sweep (0..4).
- `pass` out 1: `err_count == 0`; valid from `done` until the next `start`.

## Operation
- FSM states: IDLE, DRIVE, RESULT, FIN.
- IDLE:
  - `start` high → DRIVE, with `idx` = 0, settle counter = 0, `err_count` = 0.
- DRIVE:
  - `a_o` = `idx[1]`, `c_o` = `idx[0]`, held stable.
  - The settle counter increments each cycle.
  - When counter == `SETTLE-1`: register `y_i` into `res_y`, compute `res_ok` → RESULT.
- RESULT:
  - `res_valid` = 1; `res_idx`, `res_y`, `res_ok`, `a_o`, `c_o` held stable until the handshake.
  - The handshake completes in a cycle where `res_valid && res_ready`.
  - On handshake: if `!res_ok`, `err_count` increments.
  - Then: if `idx` == 3 → FIN; otherwise `idx`+1, counter = 0 → DRIVE.
- FIN:
  - `done` = 1 for one cycle → IDLE.
  - `err_count` and `pass` hold until the next `start`.
- `start` is ignored while `busy`.
- Reset values:
  - State IDLE, `idx` = 0, counter = 0.
  - `a_o`, `c_o`, `res_valid`, `res_idx`, `res_y`, `res_ok`, `busy`, `done`, `err_count` all = 0.
  - `pass` = 1.
- Reset mid-sweep: returns to IDLE with reset values on the next edge; a pending result is discarded with no handshake.
- `err_count` saturates at 4. It cannot overflow in one sweep.

## Timing
- `start` sampled at edge 0 → DRIVE from cycle 1, with `a_o`/`c_o` valid from cycle 1.
- `y_i` is sampled at the end of DRIVE cycle `SETTLE`.
- `res_valid` rises one cycle after that sample.
- With `res_ready` tied high, each vector takes `SETTLE+1` cycles, and `done` pulses in cycle `4*(SETTLE+1)+1`. For `SETTLE`=1 this is cycle 9.
- Backpressure: each cycle `res_ready` is low in RESULT adds one cycle.
- `y_i` is treated as combinational from `a_o`/`c_o`; the mux is not registered.

## Configuration
- `MUX_TT_SEQ_ABORT_EN` defined:
  - A handshake with `res_ok` = 0 sends the FSM directly to FIN, skipping the remaining vectors.
  - `err_count` = 1 at `done`.
- Not defined: all four vectors are always swept, and mismatches only accumulate.

## Structure
- Package `mux_tt_seq_pkg`:
  - state enum `tt_state_t` (IDLE, DRIVE, RESULT, FIN);
  - `N_VEC` = 4;
  - `IDX_W` = 2;
  - `EXP_XOR` = 4'b0110.
- Sub-module `tt_settle_timer`:
  - 4-bit counter with `clr` and `en` inputs;
  - asserts `expired` when count == `SETTLE-1`.
- Top: FSM, index register, result registers, error counter.

## Test plan
- `SETTLE`=1, `res_ready`=1, with `mux_a_not_a` connected:
  - Stimulus: `start` pulse.
  - Expected results: `(idx,y)` = (0,0), (1,1), (2,1), (3,0), all with `res_ok` = 1.
  - `done` in cycle 9, `err_count` = 0, `pass` = 1.
- Faulty DUT, `y_i` stuck at 0:
  - Expected: `res_ok` = 0 at idx 1 and 2.
  - `err_count` = 2, `pass` = 0.
  - With `MUX_TT_SEQ_ABORT_EN`: `done` one cycle after the idx 1 handshake, `err_count` = 1.
- Backpressure:
  - Stimulus: `res_ready` low 3 cycles at each result.
  - Expected: results stable while waiting, `done` at cycle 21, no vector lost or duplicated.
- `SETTLE`=4:
  - Expected: `a_o`/`c_o` held 4 cycles per vector, `done` at cycle 21.
- `rst` during idx 2 RESULT:
  - Expected: next cycle IDLE with all outputs at reset values.
  - A fresh `start` then sweeps from idx 0.
- `start` held high throughout:
  - Expected: no restart while `busy`.
  - A new sweep begins one cycle after the `done` pulse, i.e. on the IDLE cycle.

Source files
------------

// File: rtl/mux_tt_seq_pkg.sv
// mux_tt_seq_pkg
//   Shared types and constants for the mux_a_not_a truth-table sequencer.
//   tt_state_t : sequencer FSM states
//   N_VEC      : number of input vectors swept ({a,c} combinations)
//   IDX_W      : width of the vector index
//   EXP_XOR    : expected y table for y = c ? ~a : a, indexed by {a,c}
package mux_tt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2,
        FIN    = 2'd3
    } tt_state_t;

    localparam int unsigned      N_VEC   = 4;
    localparam int unsigned      IDX_W   = 2;
    localparam logic [N_VEC-1:0] EXP_XOR = 4'b0110;

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer
//   4-bit settle counter used to hold each mux vector before sampling y.
//   Parameters:
//     SETTLE  : hold length in cycles (1..15)
//   Ports:
//     clk     in  : clock, rising edge
//     rst     in  : synchronous active-high reset
//     clr     in  : clear counter to 0 (wins over en)
//     en      in  : increment counter
//     expired out : count == SETTLE-1
module tt_settle_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 4'(SETTLE - 1));

endmodule

// File: rtl/mux_tt_sequencer.sv
// mux_tt_sequencer
//   Clocked stimulus/checker for the mux_a_not_a cell (y = c ? ~a : a).
//   Sweeps {a,c} over 0..3, holds each vector SETTLE cycles, samples y_i,
//   compares it to EXP_TABLE[{a,c}] and presents each result on a
//   valid/ready handshake while accumulating a mismatch count.
//   Build option: define MUX_TT_SEQ_ABORT_EN to end the sweep at the first
//   mismatching result instead of sweeping all four vectors.
//   Parameters:
//     SETTLE    : cycles each vector is held before sampling (1..15)
//     EXP_TABLE : expected y indexed by {a,c}
//   Ports:
//     clk       in  : clock, rising edge
//     rst       in  : synchronous active-high reset
//     start     in  : begin a sweep (sampled in IDLE only)
//     a_o, c_o  out : mux inputs a and c
//     y_i       in  : mux output y (combinational from a_o/c_o)
//     res_valid out : result presented
//     res_ready in  : consumer accepts result
//     res_idx   out : {a,c} of presented result
//     res_y     out : sampled y
//     res_ok    out : res_y matches EXP_TABLE[res_idx]
//     busy      out : not IDLE
//     done      out : one-cycle pulse at sweep end
//     err_count out : mismatches in current/last sweep (saturates at 4)
//     pass      out : err_count == 0
module mux_tt_sequencer
    import mux_tt_seq_pkg::*;
#(
    parameter int unsigned      SETTLE    = 1,
    parameter logic [N_VEC-1:0] EXP_TABLE = EXP_XOR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             c_o,
    input  logic             y_i,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_idx,
    output logic             res_y,
    output logic             res_ok,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err_count,
    output logic             pass
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);
    localparam logic [2:0]       ERR_MAX  = 3'(N_VEC);

    tt_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;
    logic             res_y_q, res_y_d;
    logic             res_ok_q, res_ok_d;
    logic [2:0]       err_q, err_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;
    logic last_vec;
    logic driving;

    tt_settle_timer #(
        .SETTLE(SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    // Sweep ends after the last vector, or at the first mismatch when aborting.
`ifdef MUX_TT_SEQ_ABORT_EN
    assign last_vec = (idx_q == LAST_IDX) || !res_ok_q;
`else
    assign last_vec = (idx_q == LAST_IDX);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        res_idx_d = res_idx_q;
        res_y_d   = res_y_q;
        res_ok_d  = res_ok_q;
        err_d     = err_q;
        tmr_clr   = 1'b1;
        tmr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                end
            end

            DRIVE: begin
                // Counter runs only here and is cleared as it expires, so it
                // is already 0 when the next vector starts.
                tmr_en  = 1'b1;
                tmr_clr = tmr_expired;
                if (tmr_expired) begin
                    res_y_d   = y_i;
                    res_idx_d = idx_q;
                    res_ok_d  = (y_i == EXP_TABLE[idx_q]);
                    state_d   = RESULT;
                end
            end

            RESULT: begin
                if (res_ready) begin
                    if (!res_ok_q && (err_q < ERR_MAX)) begin
                        err_d = err_q + 3'd1;
                    end
                    if (last_vec) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = DRIVE;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            res_idx_q <= '0;
            res_y_q   <= 1'b0;
            res_ok_q  <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            res_idx_q <= res_idx_d;
            res_y_q   <= res_y_d;
            res_ok_q  <= res_ok_d;
            err_q     <= err_d;
        end
    end

    // Mux inputs are parked at 0 outside an active vector.
    assign driving   = (state_q == DRIVE) || (state_q == RESULT);
    assign a_o       = driving & idx_q[1];
    assign c_o       = driving & idx_q[0];

    assign res_valid = (state_q == RESULT);
    assign res_idx   = res_idx_q;
    assign res_y     = res_y_q;
    assign res_ok    = res_ok_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign err_count = err_q;
    assign pass      = (err_q == 3'd0);

endmodule

// File: tb/tb_mux_tt_sequencer.sv
module tb_mux_tt_sequencer;

    localparam int unsigned SETTLE2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, ready, a, c, y;
    logic       rv, ry, rok, busy, done, pass;
    logic [1:0] ridx;
    logic [2:0] err;

    logic       start2, a2, c2, y2;
    logic       rv2, ry2, rok2, busy2, done2, pass2;
    logic [1:0] ridx2;
    logic [2:0] err2;

    // Mux model with injectable faults for the primary DUT.
    logic       stuck;
    logic [3:0] flip;
    assign y  = stuck ? 1'b0 : ((c ? ~a : a) ^ flip[{a, c}]);
    assign y2 = c2 ? ~a2 : a2;

    mux_tt_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .a_o(a), .c_o(c), .y_i(y),
        .res_valid(rv), .res_ready(ready), .res_idx(ridx), .res_y(ry),
        .res_ok(rok), .busy(busy), .done(done), .err_count(err), .pass(pass)
    );

    mux_tt_sequencer #(.SETTLE(SETTLE2)) u_dut4 (
        .clk(clk), .rst(rst), .start(start2), .a_o(a2), .c_o(c2), .y_i(y2),
        .res_valid(rv2), .res_ready(1'b1), .res_idx(ridx2), .res_y(ry2),
        .res_ok(rok2), .busy(busy2), .done(done2), .err_count(err2), .pass(pass2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [3:0] exp_tab;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_a", 32'(a), 0);
        chk("rst_c", 32'(c), 0);
        chk("rst_valid", 32'(rv), 0);
        chk("rst_idx", 32'(ridx), 0);
        chk("rst_y", 32'(ry), 0);
        chk("rst_ok", 32'(rok), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_pass", 32'(pass), 1);
    endtask

    // One sweep on u_dut. Stall per result drawn from [smin,smax].
    // rst_at >= 0 resets the DUT while that vector's result is pending.
    task automatic run_sweep(input int smin, input int smax, input bit stk,
                             input logic [3:0] flp, input bit hold, input int rst_at);
        logic [3:0] ey, eok;
        int nvec, errs, total, drv, n;
        logic av;
        // Reference: expected y and verdict for every vector from the rules.
        for (int k = 0; k < 4; k++) begin
            av     = (k >= 2);
            ey[k]  = stk ? 1'b0 : (((k % 2) == 1 ? ~av : av) ^ flp[k]);
            eok[k] = (ey[k] == exp_tab[k]);
        end
        nvec = 4;
`ifdef MUX_TT_SEQ_ABORT_EN
        for (int k = 3; k >= 0; k--) if (!eok[k]) nvec = k + 1;
`endif
        errs = 0;
        for (int k = 0; k < nvec; k++) if (!eok[k]) errs++;

        stuck = stk;
        flip  = flp;
        cyc   = 0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        total = 0;
        for (int k = 0; k < nvec; k++) begin
            drv = 0;
            while (!rv && drv < 20) begin
                chk("drive_a", 32'(a), 32'(k / 2));
                chk("drive_c", 32'(c), 32'(k % 2));
                drv++;
                tick();
            end
            if (!rv) begin
                chk("valid_timeout", 0, 1);
                return;
            end
            chk("settle_len", 32'(drv), 1);
            chk("res_idx", 32'(ridx), 32'(k));
            chk("res_y", 32'(ry), 32'(ey[k]));
            chk("res_ok", 32'(rok), 32'(eok[k]));
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk_reset();
                return;
            end
            n = $urandom_range(smax, smin);
            ready = 1'b0;
            repeat (n) begin
                tick();
                chk("stall_valid", 32'(rv), 1);
                chk("stall_idx", 32'(ridx), 32'(k));
                chk("stall_y", 32'(ry), 32'(ey[k]));
                chk("stall_a", 32'(a), 32'(k / 2));
                chk("stall_c", 32'(c), 32'(k % 2));
            end
            ready = 1'b1;
            tick();
            ready = 1'b0;
            total += 2 + n;
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_cycle", 32'(cyc), 32'(total + 1));
        chk("done_busy", 32'(busy), 1);
        chk("done_err", 32'(err), 32'(errs));
        chk("done_pass", 32'(pass), 32'(errs == 0));
        tick();
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_err", 32'(err), 32'(errs));
        chk("idle_pass", 32'(pass), 32'(errs == 0));
        if (hold) begin
            tick();
            chk("restart_busy", 32'(busy), 1);
            chk("restart_a", 32'(a), 0);
            chk("restart_c", 32'(c), 0);
            chk("restart_err", 32'(err), 0);
            start = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk_reset();
        end
    endtask

    // SETTLE=4 instance with ready tied high: cycle-exact schedule.
    task automatic run_settle4();
        int k, p;
        cyc    = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int t = 1; t <= 4 * (SETTLE2 + 1); t++) begin
            k = (t - 1) / (SETTLE2 + 1);
            p = (t - 1) % (SETTLE2 + 1);
            chk("s4_a", 32'(a2), 32'(k / 2));
            chk("s4_c", 32'(c2), 32'(k % 2));
            chk("s4_valid", 32'(rv2), 32'(p == SETTLE2));
            if (p == SETTLE2) begin
                chk("s4_idx", 32'(ridx2), 32'(k));
                chk("s4_ok", 32'(rok2), 1);
            end
            tick();
        end
        chk("s4_done", 32'(done2), 1);
        chk("s4_done_cycle", 32'(cyc), 21);
        chk("s4_err", 32'(err2), 0);
        chk("s4_pass", 32'(pass2), 1);
        tick();
        chk("s4_idle", 32'(busy2), 0);
    endtask

    initial begin
        exp_tab = 4'b0110;
        rst     = 1'b1;
        start   = 1'b0;
        start2  = 1'b0;
        ready   = 1'b0;
        stuck   = 1'b0;
        flip    = 4'b0000;
        repeat (2) tick();
        chk_reset();
        chk("rst4_busy", 32'(busy2), 0);
        chk("rst4_pass", 32'(pass2), 1);
        rst = 1'b0;
        tick();

        run_sweep(0, 0, 1'b0, 4'b0000, 1'b0, -1);   // clean, ready high
        run_sweep(0, 0, 1'b1, 4'b0000, 1'b0, -1);   // y stuck at 0
        run_sweep(3, 3, 1'b0, 4'b0000, 1'b0, -1);   // 3-cycle backpressure
        run_settle4();
        run_sweep(0, 1, 1'b0, 4'b0000, 1'b0, 2);    // reset at idx 2 result
        tick();
        run_sweep(0, 0, 1'b0, 4'b0000, 1'b0, -1);   // fresh sweep after reset
        run_sweep(0, 0, 1'b0, 4'b0000, 1'b1, -1);   // start held high
        tick();
        for (int r = 0; r < 8; r++) begin
            run_sweep(0, $urandom_range(4, 0), ($urandom_range(3, 0) == 0),
                      4'($urandom), 1'b0, -1);
            repeat ($urandom_range(2, 0)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
